// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Sequencing controller for the front-end fetch datapath. Owns the fetch
//   PC, issues 8-byte-aligned I-cache requests (up to MAX_OUTSTANDING in
//   flight), tags each request with the current redirect epoch, steers
//   in-order responses to the instruction buffer (dropping stale ones),
//   arbitrates ROB / fence.i / branch-predictor redirects and sequences the
//   fence.i drain-then-invalidate flow.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   rob_redir_val_i/pc_i   ROB redirect, highest priority
//   fence_i_val_i/pc_i     fence.i pulse and resume PC
//   bp_redir_val_i/pc_i    branch-predictor redirect, lowest priority
//   icache_req_rdy_i       cache accepts a request this cycle
//   icache_req_val_o       request valid
//   icache_req_addr_o      request address, bits[2:0] always zero
//   icache_resp_val_i      in-order response strobe
//   icache_inv_o           one-cycle I-cache invalidate pulse
//   ib_free_i              free instruction-buffer slots (0..4)
//   ib_wr_o                write current response into the buffer
//   ib_pc_o                PC of the response block
//   ib_skip0_o             slot 0 of the block is not a valid instruction
//   busy_o                 not in steady RUN or requests still in flight
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int unsigned               CPU_ADDR_BITS   = 32,
  parameter int unsigned               MAX_OUTSTANDING = 2,
  parameter logic [CPU_ADDR_BITS-1:0]  RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rob_redir_val_i,
  input  logic [CPU_ADDR_BITS-1:0] rob_redir_pc_i,
  input  logic                     bp_redir_val_i,
  input  logic [CPU_ADDR_BITS-1:0] bp_redir_pc_i,
  input  logic                     fence_i_val_i,
  input  logic [CPU_ADDR_BITS-1:0] fence_i_pc_i,
  input  logic                     icache_req_rdy_i,
  output logic                     icache_req_val_o,
  output logic [CPU_ADDR_BITS-1:0] icache_req_addr_o,
  input  logic                     icache_resp_val_i,
  output logic                     icache_inv_o,
  input  logic [2:0]               ib_free_i,
  output logic                     ib_wr_o,
  output logic [CPU_ADDR_BITS-1:0] ib_pc_o,
  output logic                     ib_skip0_o,
  output logic                     busy_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CMP_W = (CNT_W > 3) ? CNT_W : 3;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CPU_ADDR_BITS-1:0] pc_q, pc_d;
  logic                     epoch_q, epoch_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;

  // Tag FIFO: PC (including bit 2, needed for skip0) and epoch per request
  logic [CPU_ADDR_BITS-1:0] tag_pc_q [MAX_OUTSTANDING];
  logic                     tag_ep_q [MAX_OUTSTANDING];

  logic                     kill;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     inv_fire;
  logic [CPU_ADDR_BITS-1:0] aligned_pc;
  logic [CPU_ADDR_BITS-1:0] head_pc;
  logic                     head_ep;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    // A redirect that is actually honoured this cycle blocks both issue and
    // buffer writes; in DRAIN only the ROB can redirect.
    kill = ((state_q != BOOT) && rob_redir_val_i) ||
           ((state_q == RUN) && (fence_i_val_i || bp_redir_val_i));

    aligned_pc = {pc_q[CPU_ADDR_BITS-1:3], 3'b000};

    // Credit rule: every in-flight request holds one buffer slot in reserve
    issue = (state_q == RUN) && !kill &&
            (outstanding_q < CNT_W'(MAX_OUTSTANDING)) &&
            (CMP_W'(ib_free_i) > CMP_W'(outstanding_q));
    push  = issue && icache_req_rdy_i;
    pop   = icache_resp_val_i && (outstanding_q != '0);

    head_pc = tag_pc_q[rd_ptr_q];
    head_ep = tag_ep_q[rd_ptr_q];

    // Invalidate once the drain is complete, unless a ROB redirect moves the
    // resume point in that same cycle.
    inv_fire = (state_q == DRAIN) && (outstanding_q == '0) && !rob_redir_val_i;

    icache_req_val_o  = issue;
    icache_req_addr_o = issue ? aligned_pc : '0;
    ib_wr_o           = pop && (head_ep == epoch_q) && !kill;
    ib_pc_o           = pop ? head_pc : '0;
    ib_skip0_o        = pop && head_pc[2];
    icache_inv_o      = inv_fire;
    busy_o            = (state_q != RUN) || (outstanding_q != '0);

    outstanding_d = outstanding_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d      = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d      = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;

    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (rob_redir_val_i) begin
          pc_d    = rob_redir_pc_i;
          epoch_d = ~epoch_q;
        end else if (fence_i_val_i) begin
          pc_d    = fence_i_pc_i;
          epoch_d = ~epoch_q;
          state_d = DRAIN;
        end else if (bp_redir_val_i) begin
          pc_d    = bp_redir_pc_i;
          epoch_d = ~epoch_q;
        end else if (push) begin
          pc_d = aligned_pc + CPU_ADDR_BITS'(8);
        end
      end
      DRAIN: begin
        if (rob_redir_val_i) begin
          pc_d    = rob_redir_pc_i;
          epoch_d = ~epoch_q;
        end else if (inv_fire) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // All architectural state, including the tag FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      epoch_q       <= 1'b0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_pc_q[i] <= '0;
        tag_ep_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (push) begin
        tag_pc_q[wr_ptr_q] <= pc_q;
        tag_ep_q[wr_ptr_q] <= epoch_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl. A queue-based reference model tracks
//   the fetch PC, epoch and in-flight tags; every cycle the DUT outputs are
//   compared against it. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int MAXO = 2;

  logic        clk;
  logic        rst_n;
  logic        robVal, bpVal, fenceVal, reqRdy, respVal;
  logic [31:0] robPc, bpPc, fencePc;
  logic [2:0]  ibFree;
  logic        reqVal, inv, ibWr, ibSkip0, busy;
  logic [31:0] reqAddr, ibPc;

  fetch_ctrl #(
    .CPU_ADDR_BITS   (32),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0000_0100)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rob_redir_val_i   (robVal),
    .rob_redir_pc_i    (robPc),
    .bp_redir_val_i    (bpVal),
    .bp_redir_pc_i     (bpPc),
    .fence_i_val_i     (fenceVal),
    .fence_i_pc_i      (fencePc),
    .icache_req_rdy_i  (reqRdy),
    .icache_req_val_o  (reqVal),
    .icache_req_addr_o (reqAddr),
    .icache_resp_val_i (respVal),
    .icache_inv_o      (inv),
    .ib_free_i         (ibFree),
    .ib_wr_o           (ibWr),
    .ib_pc_o           (ibPc),
    .ib_skip0_o        (ibSkip0),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        ep;
  } tagT;

  // reference model state
  tagT         inFlight[$];
  logic [31:0] mPc;
  logic        mEp;
  bit          mBooting;
  bit          mDraining;

  // expectations for the current cycle
  bit          expReq, expPop, expWr, expInv, expBusy, expSkip;
  logic [31:0] expAddr, expIbPc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rob, input logic [31:0] rPc, input bit bp,
                               input logic [31:0] bPc, input bit fence, input logic [31:0] fPc,
                               input bit rdy, input bit resp, input logic [2:0] free);
    robVal   = rob;   robPc   = rPc;
    bpVal    = bp;    bpPc    = bPc;
    fenceVal = fence; fencePc = fPc;
    reqRdy   = rdy;   respVal = resp;
    ibFree   = free;
  endtask

  task automatic modelReset();
    inFlight.delete();
    mPc       = 32'h0000_0100;
    mEp       = 1'b0;
    mBooting  = 1'b1;
    mDraining = 1'b0;
  endtask

  // Let combinational outputs settle, derive expectations and compare
  task automatic settle();
    bit killed;
    #2;
    killed  = (!mBooting && robVal) || (!mBooting && !mDraining && (fenceVal || bpVal));
    expReq  = !mBooting && !mDraining && !killed && (inFlight.size() < MAXO) &&
              (int'(ibFree) > inFlight.size());
    expAddr = expReq ? (mPc & ~32'h7) : 32'h0;
    expPop  = respVal && (inFlight.size() > 0);
    expWr   = expPop && (inFlight[0].ep == mEp) && !killed;
    expIbPc = expPop ? inFlight[0].pc : 32'h0;
    expSkip = expPop && inFlight[0].pc[2];
    expInv  = mDraining && (inFlight.size() == 0) && !robVal;
    expBusy = mBooting || mDraining || (inFlight.size() != 0);
    checkOutput("req_val",  {31'b0, reqVal},  {31'b0, expReq});
    checkOutput("req_addr", reqAddr,          expAddr);
    checkOutput("ib_wr",    {31'b0, ibWr},    {31'b0, expWr});
    checkOutput("ib_pc",    ibPc,             expIbPc);
    checkOutput("ib_skip0", {31'b0, ibSkip0}, {31'b0, expSkip});
    checkOutput("inv",      {31'b0, inv},     {31'b0, expInv});
    checkOutput("busy",     {31'b0, busy},    {31'b0, expBusy});
  endtask

  // Apply the clock edge to the model and move to the next drive point
  task automatic advance();
    bit pushed;
    pushed = expReq && reqRdy;
    if (expPop) void'(inFlight.pop_front());
    if (pushed) inFlight.push_back('{pc: mPc, ep: mEp});
    if (mBooting) begin
      mBooting = 1'b0;
    end else if (!mDraining) begin
      if (robVal) begin
        mPc = robPc; mEp = ~mEp;
      end else if (fenceVal) begin
        mPc = fencePc; mEp = ~mEp; mDraining = 1'b1;
      end else if (bpVal) begin
        mPc = bpPc; mEp = ~mEp;
      end else if (pushed) begin
        mPc = (mPc & ~32'h7) + 32'd8;
      end
    end else begin
      if (robVal) begin
        mPc = robPc; mEp = ~mEp;
      end else if (expInv) begin
        mDraining = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle(input bit rdy, input bit resp);
    applyStimulus(0, 0, 0, 0, 0, 0, rdy, resp, 3'd4);
    cycle();
  endtask

  // Asynchronous reset taken mid-cycle, released at a negedge
  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
    #2;
    modelReset();
    checkOutput("rst_req_val", {31'b0, reqVal}, 32'h0);
    checkOutput("rst_inv",     {31'b0, inv},    32'h0);
    checkOutput("rst_ib_wr",   {31'b0, ibWr},   32'h0);
    checkOutput("rst_busy",    {31'b0, busy},   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
    modelReset();
    #3;
    checkOutput("rst_req_val",  {31'b0, reqVal},  32'h0);
    checkOutput("rst_req_addr", reqAddr,          32'h0);
    checkOutput("rst_ib_pc",    ibPc,             32'h0);
    checkOutput("rst_skip0",    {31'b0, ibSkip0}, 32'h0);
    checkOutput("rst_busy",     {31'b0, busy},    32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: sequential fetch from RESET_PC, responses one cycle later
    idle(1, 0);                                   // BOOT cycle
    idle(1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3'd4);
    settle();
    checkOutput("s1_addr1", reqAddr, 32'h108);
    checkOutput("s1_ibpc0", ibPc, 32'h100);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3'd4);
    settle();
    checkOutput("s1_addr2", reqAddr, 32'h110);
    checkOutput("s1_ibpc1", ibPc, 32'h108);
    advance();
    idle(0, 1);

    // Scenario 2: ROB redirect with two requests in flight
    idle(1, 0);
    idle(1, 0);
    applyStimulus(1, 32'h204, 0, 0, 0, 0, 1, 0, 3'd4);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3'd4);
    settle();
    checkOutput("s2_drop0", {31'b0, ibWr}, 32'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3'd4);
    settle();
    checkOutput("s2_drop1", {31'b0, ibWr}, 32'h0);
    checkOutput("s2_addr", reqAddr, 32'h200);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd4);
    settle();
    checkOutput("s2_wr", {31'b0, ibWr}, 32'h1);
    checkOutput("s2_skip0", {31'b0, ibSkip0}, 32'h1);
    advance();

    // Scenario 3: simultaneous ROB and predictor redirect
    applyStimulus(1, 32'h300, 1, 32'h400, 0, 0, 1, 0, 3'd4);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 3'd4);
    settle();
    checkOutput("s3_addr", reqAddr, 32'h300);
    advance();
    idle(0, 1);

    // Scenario 4: credit rule with one request outstanding
    idle(1, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 3'd1);
      settle();
      checkOutput("s4_noissue", {31'b0, reqVal}, 32'h0);
      advance();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 3'd2);
    settle();
    checkOutput("s4_issue", {31'b0, reqVal}, 32'h1);
    advance();
    idle(0, 1);
    idle(0, 1);

    // Scenario 5: fence.i with two outstanding, responses at +3 and +5
    idle(1, 0);
    idle(1, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h500, 1, 0, 3'd4);
    cycle();
    idle(1, 0);
    idle(1, 0);
    idle(1, 1);
    idle(1, 0);
    idle(1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 3'd4);
    settle();
    checkOutput("s5_inv", {31'b0, inv}, 32'h1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 3'd4);
    settle();
    checkOutput("s5_inv_off", {31'b0, inv}, 32'h0);
    checkOutput("s5_addr", reqAddr, 32'h500);
    advance();
    idle(0, 1);

    // Scenario 6: address wrap and spurious response
    applyStimulus(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 1, 0, 3'd4);
    cycle();
    idle(1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 3'd4);
    settle();
    checkOutput("s6_wrap", reqAddr, 32'h0);
    advance();
    idle(0, 1);
    idle(0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd4);
    settle();
    checkOutput("s6_spur_wr", {31'b0, ibWr}, 32'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
    settle();
    checkOutput("s6_spur_busy", {31'b0, busy}, 32'h0);
    advance();

    // Reset while draining a fence.i: no invalidate may follow
    idle(1, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h600, 1, 0, 3'd4);
    cycle();
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd4);
      settle();
      checkOutput("rd_no_inv", {31'b0, inv}, 32'h0);
      advance();
    end

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bit rob, bp, fen, rdy, resp;
      rob  = ($urandom_range(0, 15) == 0);
      bp   = ($urandom_range(0, 7) == 0);
      fen  = ($urandom_range(0, 19) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      resp = (inFlight.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      applyStimulus(rob, $urandom, bp, $urandom, fen, $urandom, rdy, resp,
                    3'($urandom_range(0, 4)));
      cycle();
      if ($urandom_range(0, 299) == 0) doReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
